// File: rtl/video_buf_pkg.sv
// Shared types and constants for the GB-to-display triple-buffer video path.
//   buf_idx_t          : index of one of the three video buffer RAMs
//   *_IDX_RST          : buffer assignment after reset
//   GB_FRAME_W/H       : GB frame geometry
//   FRAME_PIXELS       : pixels per GB frame
//   MIN_PIXELS         : strobes needed before a frame counts as complete
//   ADDR_W / STAT_W    : write-address and statistics counter widths
package video_buf_pkg;

  typedef logic [1:0] buf_idx_t;

  localparam buf_idx_t WR_IDX_RST  = 2'd0;
  localparam buf_idx_t RD_IDX_RST  = 2'd1;
  localparam buf_idx_t RDY_IDX_RST = 2'd2;

  localparam int unsigned GB_FRAME_W   = 160;
  localparam int unsigned GB_FRAME_H   = 144;
  localparam int unsigned FRAME_PIXELS = GB_FRAME_W * GB_FRAME_H;
  localparam int unsigned MIN_PIXELS   = 11601;
  localparam int unsigned ADDR_W       = 15;
  localparam int unsigned STAT_W       = 16;

endpackage

// File: rtl/frame_buffer_scheduler_if.sv
// Capture/display side signal bundle of the frame buffer scheduler.
//   wr_pix_stb   : one-cycle pulse per valid GB pixel
//   gb_vsync     : GB vsync level, rising edge ends a GB frame
//   vsync        : display vsync level (active low), falling edge starts a display frame
//   wr_addr      : write address inside the active write buffer
//   wr_index     : buffer being written
//   rd_index     : buffer being displayed
//   rd_frame_new : one-cycle pulse when rd_index moves to a fresh frame
//   drop_cnt     : complete frames overwritten before display
//   repeat_cnt   : display frames that re-showed the old buffer
// master = capture/display front end, slave = scheduler.
interface frame_buffer_scheduler_if;
  import video_buf_pkg::*;

  logic              wr_pix_stb;
  logic              gb_vsync;
  logic              vsync;
  logic [ADDR_W-1:0] wr_addr;
  buf_idx_t          wr_index;
  buf_idx_t          rd_index;
  logic              rd_frame_new;
  logic [STAT_W-1:0] drop_cnt;
  logic [STAT_W-1:0] repeat_cnt;

  modport master (
    output wr_pix_stb, gb_vsync, vsync,
    input  wr_addr, wr_index, rd_index, rd_frame_new, drop_cnt, repeat_cnt
  );

  modport slave (
    input  wr_pix_stb, gb_vsync, vsync,
    output wr_addr, wr_index, rd_index, rd_frame_new, drop_cnt, repeat_cnt
  );

endinterface

// File: rtl/video_edge_det.sv
// Single-level edge detector against the previous-cycle sample.
//   pclk, rst_n : clock and synchronous active-low reset
//   i_level     : level input, already synchronous to pclk
//   o_rise_c    : combinational rise pulse (level high, previous sample low)
//   o_fall_c    : combinational fall pulse (level low, previous sample high)
// During reset the history register loads the current level so that a level
// already asserted when reset is released never reads as an edge.
module video_edge_det (
  input  logic pclk,
  input  logic rst_n,
  input  logic i_level,
  output logic o_rise_c,
  output logic o_fall_c
);

  logic r_prev;

  // History register: same load in and out of reset.
  always_ff @(posedge pclk) begin
    r_prev <= i_level;
  end

  assign o_rise_c = rst_n &  i_level & ~r_prev;
  assign o_fall_c = rst_n & ~i_level &  r_prev;

endmodule

// File: rtl/frame_buffer_scheduler.sv
// Triple-buffer rotation for the GB-to-display video path.
//   pclk, rst_n : clock and synchronous active-low reset
//   bus         : frame_buffer_scheduler_if.slave (strobes/vsyncs in,
//                 wr_addr, wr_index, rd_index, rd_frame_new, stats out)
// The writer and the display always own different buffers; a third buffer
// (rdy) holds the newest complete GB frame until the display picks it up.
// Frames with fewer than MIN_PIXELS strobes are rewritten in place.
// Optional feature macro: FRAME_STATS_EN builds saturating drop/repeat
// counters; without it both counters read as zero and no flops are built.
module frame_buffer_scheduler
  import video_buf_pkg::*;
(
  input  logic                     pclk,
  input  logic                     rst_n,
  frame_buffer_scheduler_if.slave  bus
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_PIXELS - 1);
  localparam logic [ADDR_W-1:0] PIX_FULL  = ADDR_W'(FRAME_PIXELS);
  localparam logic [ADDR_W-1:0] PIX_MIN   = ADDR_W'(MIN_PIXELS);

  logic w_gb_rise;
  logic w_disp_start;
  logic w_unused_gb_fall;
  logic w_unused_disp_rise;
  logic w_frame_done;

  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_pix_cnt;

  buf_idx_t r_wr_idx, r_rd_idx, r_rdy_idx;
  logic     r_fresh, r_frame_new;
  buf_idx_t w_wr_nxt, w_rd_nxt, w_rdy_nxt;
  logic     w_fresh_nxt, w_frame_new_nxt;

  video_edge_det u_gb_edge (
    .pclk     (pclk),
    .rst_n    (rst_n),
    .i_level  (bus.gb_vsync),
    .o_rise_c (w_gb_rise),
    .o_fall_c (w_unused_gb_fall)
  );

  video_edge_det u_disp_edge (
    .pclk     (pclk),
    .rst_n    (rst_n),
    .i_level  (bus.vsync),
    .o_rise_c (w_unused_disp_rise),
    .o_fall_c (w_disp_start)
  );

  assign w_frame_done = w_gb_rise & (r_pix_cnt >= PIX_MIN);

  // Write address and pixel count; a strobe coincident with frame end is dropped.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      r_wr_addr <= '0;
      r_pix_cnt <= '0;
    end else if (w_gb_rise) begin
      r_wr_addr <= '0;
      r_pix_cnt <= '0;
    end else if (bus.wr_pix_stb) begin
      r_wr_addr <= (r_wr_addr == ADDR_LAST) ? '0 : r_wr_addr + ADDR_W'(1);
      if (r_pix_cnt != PIX_FULL) begin
        r_pix_cnt <= r_pix_cnt + ADDR_W'(1);
      end
    end
  end

  // Buffer rotation. On a coincident complete frame and display start the
  // writer takes the buffer the display releases and rdy is left alone.
  always_comb begin
    w_wr_nxt        = r_wr_idx;
    w_rd_nxt        = r_rd_idx;
    w_rdy_nxt       = r_rdy_idx;
    w_fresh_nxt     = r_fresh;
    w_frame_new_nxt = 1'b0;
    if (w_frame_done && w_disp_start) begin
      w_rd_nxt        = r_wr_idx;
      w_wr_nxt        = r_rd_idx;
      w_fresh_nxt     = 1'b0;
      w_frame_new_nxt = 1'b1;
    end else if (w_frame_done) begin
      w_rdy_nxt   = r_wr_idx;
      w_wr_nxt    = r_rdy_idx;
      w_fresh_nxt = 1'b1;
    end else if (w_disp_start && r_fresh) begin
      w_rd_nxt        = r_rdy_idx;
      w_rdy_nxt       = r_rd_idx;
      w_fresh_nxt     = 1'b0;
      w_frame_new_nxt = 1'b1;
    end
  end

  // Rotation state register.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      r_wr_idx    <= WR_IDX_RST;
      r_rd_idx    <= RD_IDX_RST;
      r_rdy_idx   <= RDY_IDX_RST;
      r_fresh     <= 1'b0;
      r_frame_new <= 1'b0;
    end else begin
      r_wr_idx    <= w_wr_nxt;
      r_rd_idx    <= w_rd_nxt;
      r_rdy_idx   <= w_rdy_nxt;
      r_fresh     <= w_fresh_nxt;
      r_frame_new <= w_frame_new_nxt;
    end
  end

  assign bus.wr_addr      = r_wr_addr;
  assign bus.wr_index     = r_wr_idx;
  assign bus.rd_index     = r_rd_idx;
  assign bus.rd_frame_new = r_frame_new;

`ifdef FRAME_STATS_EN
  logic              w_drop_inc, w_repeat_inc;
  logic [STAT_W-1:0] r_drop_cnt, r_repeat_cnt;

  // A complete frame replacing an unshown one is a drop; a display start
  // with nothing new (and no frame completing alongside) is a repeat.
  assign w_drop_inc   = w_frame_done & r_fresh;
  assign w_repeat_inc = w_disp_start & ~w_frame_done & ~r_fresh;

  // Saturating statistics counters.
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      r_drop_cnt   <= '0;
      r_repeat_cnt <= '0;
    end else begin
      if (w_drop_inc && (r_drop_cnt != '1)) begin
        r_drop_cnt <= r_drop_cnt + STAT_W'(1);
      end
      if (w_repeat_inc && (r_repeat_cnt != '1)) begin
        r_repeat_cnt <= r_repeat_cnt + STAT_W'(1);
      end
    end
  end

  assign bus.drop_cnt   = r_drop_cnt;
  assign bus.repeat_cnt = r_repeat_cnt;
`else
  assign bus.drop_cnt   = '0;
  assign bus.repeat_cnt = '0;
`endif

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Bench for frame_buffer_scheduler: directed scenarios with literal
// expectations plus a per-cycle comparison against a frame-level model.
module tb_frame_buffer_scheduler;
  import video_buf_pkg::*;

`ifdef FRAME_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif
  localparam int STAT_MAX = 65535;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frame_buffer_scheduler_if u_if ();

  frame_buffer_scheduler dut (
    .pclk  (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  typedef struct {
    int wr, rd, rdy;
    bit fresh;
    int addr, pix;
    bit newp;
    int drop, rep;
    bit pg, pv;
  } mstate_t;

  mstate_t m;

  // Frame-level model: one call per clock with the inputs seen at that edge.
  function automatic mstate_t mstep(input mstate_t s, input bit rn, input bit stb,
                                    input bit gb, input bit vs);
    mstate_t n = s;
    bit w_end, r_start, complete;
    n.pg   = gb;
    n.pv   = vs;
    n.newp = 1'b0;
    if (!rn) begin
      n.wr = 0; n.rd = 1; n.rdy = 2; n.fresh = 1'b0;
      n.addr = 0; n.pix = 0; n.drop = 0; n.rep = 0;
      return n;
    end
    w_end    = gb && !s.pg;
    r_start  = !vs && s.pv;
    complete = w_end && (s.pix >= int'(MIN_PIXELS));
    if (w_end) begin
      n.addr = 0;
      n.pix  = 0;
    end else if (stb) begin
      n.addr = (s.addr + 1) % int'(FRAME_PIXELS);
      n.pix  = (s.pix < int'(FRAME_PIXELS)) ? s.pix + 1 : s.pix;
    end
    if (complete && s.fresh && s.drop < STAT_MAX) n.drop = s.drop + 1;
    if (complete && r_start) begin
      n.rd = s.wr; n.wr = s.rd; n.fresh = 1'b0; n.newp = 1'b1;
    end else if (complete) begin
      n.rdy = s.wr; n.wr = s.rdy; n.fresh = 1'b1;
    end else if (r_start) begin
      if (s.fresh) begin
        n.rd = s.rdy; n.rdy = s.rd; n.fresh = 1'b0; n.newp = 1'b1;
      end else if (s.rep < STAT_MAX) begin
        n.rep = s.rep + 1;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m <= mstep(m, rst_n, u_if.wr_pix_stb, u_if.gb_vsync, u_if.vsync);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("wr_addr",      32'(u_if.wr_addr),      m.addr);
      chk("wr_index",     32'(u_if.wr_index),     m.wr);
      chk("rd_index",     32'(u_if.rd_index),     m.rd);
      chk("rd_frame_new", 32'(u_if.rd_frame_new), 32'(m.newp));
      chk("drop_cnt",     32'(u_if.drop_cnt),     STATS_ON ? m.drop : 0);
      chk("repeat_cnt",   32'(u_if.repeat_cnt),   STATS_ON ? m.rep : 0);
      chk("idx_legal", 32'((u_if.wr_index != u_if.rd_index) &&
                           (u_if.wr_index != 2'd3) && (u_if.rd_index != 2'd3)), 1);
    end
  end

  task automatic tick(input bit stb, input bit gb, input bit vs);
    @(negedge clk);
    u_if.wr_pix_stb = stb;
    u_if.gb_vsync   = gb;
    u_if.vsync      = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    u_if.wr_pix_stb = 1'b0;
    u_if.gb_vsync   = 1'b0;
    u_if.vsync      = 1'b1;
    @(posedge clk);
    #1;
    chk_on = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic gb_end();
    tick(1'b0, 1'b1, 1'b1);
  endtask

  task automatic disp_start();
    tick(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit g, v;
    u_if.wr_pix_stb = 1'b0;
    u_if.gb_vsync   = 1'b0;
    u_if.vsync      = 1'b1;

    // Reset values
    do_reset();
    chk("rst_wr_index", 32'(u_if.wr_index), 0);
    chk("rst_rd_index", 32'(u_if.rd_index), 1);
    chk("rst_wr_addr",  32'(u_if.wr_addr),  0);
    chk("rst_new",      32'(u_if.rd_frame_new), 0);

    // Full frame with address wrap, then promotion to display
    strobes(23040);
    chk("s1_wrap_addr", 32'(u_if.wr_addr), 0);
    strobes(1);
    chk("s1_addr_23041", 32'(u_if.wr_addr), 1);
    gb_end();
    chk("s1_wr_index", 32'(u_if.wr_index), 2);
    chk("s1_rd_index", 32'(u_if.rd_index), 1);
    chk("s1_wr_addr",  32'(u_if.wr_addr),  0);
    chk("s1_m_rdy",    32'(m.rdy), 0);
    chk("s1_m_fresh",  32'(m.fresh), 1);
    tick(1'b0, 1'b0, 1'b1);
    disp_start();
    chk("s1_rd_after", 32'(u_if.rd_index), 0);
    chk("s1_new",      32'(u_if.rd_frame_new), 1);
    chk("s1_m_rdy2",   32'(m.rdy), 1);
    tick(1'b0, 1'b0, 1'b1);
    chk("s1_new_clr",  32'(u_if.rd_frame_new), 0);

    // Short frame is rewritten; display repeats
    do_reset();
    strobes(100);
    gb_end();
    chk("s2_wr_index", 32'(u_if.wr_index), 0);
    chk("s2_rd_index", 32'(u_if.rd_index), 1);
    tick(1'b0, 1'b0, 1'b1);
    disp_start();
    chk("s2_no_new",  32'(u_if.rd_frame_new), 0);
    chk("s2_rd_same", 32'(u_if.rd_index), 1);
    chk("s2_repeat",  32'(u_if.repeat_cnt), STATS_ON ? 1 : 0);
    tick(1'b0, 1'b0, 1'b1);

    // Completion threshold, then two complete frames with no display start
    do_reset();
    strobes(11600);
    gb_end();
    chk("s3_below_min", 32'(u_if.wr_index), 0);
    strobes(11601);
    gb_end();
    chk("s3_first_wr", 32'(u_if.wr_index), 2);
    strobes(11601);
    gb_end();
    chk("s3_second_wr", 32'(u_if.wr_index), 0);
    chk("s3_drop",      32'(u_if.drop_cnt), STATS_ON ? 1 : 0);
    chk("s3_m_drop",    32'(m.drop), 1);
    tick(1'b0, 1'b0, 1'b1);
    disp_start();
    chk("s3_rd_second", 32'(u_if.rd_index), 2);
    chk("s3_new",       32'(u_if.rd_frame_new), 1);
    tick(1'b0, 1'b0, 1'b1);

    // Complete frame end and display start in the same cycle
    do_reset();
    strobes(11601);
    tick(1'b0, 1'b1, 1'b0);
    chk("s4_rd", 32'(u_if.rd_index), 0);
    chk("s4_wr", 32'(u_if.wr_index), 1);
    chk("s4_new", 32'(u_if.rd_frame_new), 1);
    chk("s4_m_rdy",   32'(m.rdy), 2);
    chk("s4_m_fresh", 32'(m.fresh), 0);
    chk("s4_repeat",  32'(u_if.repeat_cnt), 0);
    tick(1'b0, 1'b0, 1'b1);

    // Strobe coincident with frame end is discarded
    do_reset();
    strobes(50);
    tick(1'b1, 1'b1, 1'b1);
    chk("s5_addr0", 32'(u_if.wr_addr), 0);
    chk("s5_m_pix", 32'(m.pix), 0);
    tick(1'b1, 1'b0, 1'b1);
    chk("s5_addr1", 32'(u_if.wr_addr), 1);

    // Reset mid-frame discards a pending fresh frame
    do_reset();
    strobes(11601);
    gb_end();
    strobes(20);
    do_reset();
    chk("s7_wr_addr", 32'(u_if.wr_addr), 0);
    chk("s7_wr_index", 32'(u_if.wr_index), 0);
    tick(1'b0, 1'b0, 1'b1);
    disp_start();
    chk("s7_no_new", 32'(u_if.rd_frame_new), 0);
    chk("s7_rd", 32'(u_if.rd_index), 1);
    tick(1'b0, 1'b0, 1'b1);

    // Random mix of strobes and both vsyncs
    g = 1'b0;
    v = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) g = ~g;
      if ($urandom_range(0, 59) == 0) v = ~v;
      tick($urandom_range(0, 3) != 0, g, v);
    end
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
